// File: rtl/sargantana_itag_store.sv
// sargantana_itag_store: per-way I-cache tag/valid store with registered read, tag compare and flush sweep.
// Optional even parity per entry when ICACHE_TAG_PARITY_EN is defined.
module sargantana_itag_store #(
    parameter int ICACHE_N_WAY   = 4,
    parameter int TAG_DEPTH      = 64,
    parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int TAG_WIDHT      = 20
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic [ICACHE_N_WAY-1:0]           req_i,
    input  logic                              we_i,
    input  logic                              vbit_i,
    input  logic                              flush_i,
    input  logic [TAG_WIDHT-1:0]              data_i,
    input  logic [TAG_ADDR_WIDHT-1:0]         addr_i,
    input  logic [TAG_WIDHT-1:0]              cmp_tag_i,
    output logic                              ready_o,
    output logic                              flush_busy_o,
    output logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_way_o,
    output logic [ICACHE_N_WAY-1:0]           vbit_o,
    output logic [ICACHE_N_WAY-1:0]           hit_way_o,
    output logic                              hit_o,
    output logic [ICACHE_N_WAY-1:0]           parity_err_o
);
`ifdef ICACHE_TAG_PARITY_EN
    localparam int EW = TAG_WIDHT + 2;
`else
    localparam int EW = TAG_WIDHT + 1;
`endif
    typedef enum logic {SWEEP, IDLE} state_t;
    state_t                    state;
    logic [TAG_ADDR_WIDHT-1:0] cnt;
    logic [TAG_WIDHT-1:0]      cmp_q;
    logic [ICACHE_N_WAY-1:0]   perr_q;
    logic [ICACHE_N_WAY-1:0]   rd_err;
    logic [EW-1:0]             wr_entry;
    logic [EW-1:0]             mem [ICACHE_N_WAY][TAG_DEPTH];

    assign ready_o      = (state == IDLE) & ~flush_i;
    assign flush_busy_o = (state == SWEEP);
    assign hit_o        = |hit_way_o;
    assign parity_err_o = perr_q;
`ifdef ICACHE_TAG_PARITY_EN
    assign wr_entry = {^{vbit_i, data_i}, vbit_i, data_i};
`else
    assign wr_entry = {vbit_i, data_i};
`endif

    always_comb begin
        rd_err    = '0;
        hit_way_o = '0;
        for (int i = 0; i < ICACHE_N_WAY; i++) begin
`ifdef ICACHE_TAG_PARITY_EN
            rd_err[i] = ^mem[i][addr_i];
`endif
            hit_way_o[i] = vbit_o[i] & (tag_way_o[i*TAG_WIDHT +: TAG_WIDHT] == cmp_q);
        end
    end

    // The array itself is never reset; the sweep clears it after every reset or flush.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < ICACHE_N_WAY; i++) begin
            if (state == SWEEP)
                mem[i][cnt] <= '0;
            else if (ready_o && we_i && req_i[i])
                mem[i][addr_i] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= SWEEP;
            cnt       <= '0;
            cmp_q     <= '0;
            tag_way_o <= '0;
            vbit_o    <= '0;
            perr_q    <= '0;
        end else if (flush_i) begin
            state <= SWEEP;
            cnt   <= '0;
        end else if (state == SWEEP) begin
            cnt <= cnt + 1'b1;
            if (cnt == TAG_ADDR_WIDHT'(TAG_DEPTH - 1))
                state <= IDLE;
        end else if (!we_i && |req_i) begin
            cmp_q <= cmp_tag_i;
            for (int i = 0; i < ICACHE_N_WAY; i++) begin
                if (req_i[i]) begin
                    tag_way_o[i*TAG_WIDHT +: TAG_WIDHT] <= mem[i][addr_i][TAG_WIDHT-1:0];
                    vbit_o[i] <= mem[i][addr_i][TAG_WIDHT] & ~rd_err[i];
                    perr_q[i] <= rd_err[i];
                end
            end
        end
    end
endmodule
